// File: rtl/pwm_capture.sv
// PWM receiver: synchronizes an asynchronous PWM line, measures high time and period in clk
// cycles, and flags a line that stays stuck high or low for TIMEOUT cycles.
module pwm_capture #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    typedef enum logic [2:0] {StIdle, StArm, StHigh, StLow, StWaitLow} state_e;

    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   s, rise, fall;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] hlat_q, hlat_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             sh_q, sh_d;
    logic             sl_q, sl_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~prev_q;
    assign fall = ~s & prev_q;

    // Saturate so a fall landing exactly on TIMEOUT cannot push cnt past it.
    assign cnt_inc = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + CntOne;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            hlat_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            valid_q  <= 1'b0;
            sh_q     <= 1'b0;
            sl_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            prev_q   <= s;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hlat_q   <= hlat_d;
            period_q <= period_d;
            high_q   <= high_d;
            valid_q  <= valid_d;
            sh_q     <= sh_d;
            sl_q     <= sl_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hlat_d   = hlat_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        sh_d     = sh_q;
        sl_d     = sl_q;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            sh_d    = 1'b0;
            sl_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cnt_d   = '0;
                    state_d = StArm;
                end
                StArm: begin
                    if (rise) begin
                        cnt_d   = CntOne;
                        sl_d    = 1'b0;
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        hlat_d  = cnt_q;
                        cnt_d   = cnt_inc;
                        state_d = StLow;
                    end else if (cnt_q == TimeoutVal) begin
                        sh_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = StWaitLow;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StLow: begin
                    if (rise) begin
                        period_d = cnt_q;
                        high_d   = hlat_q;
                        valid_d  = 1'b1;
                        cnt_d    = CntOne;
                        state_d  = StHigh;
                    end else if (cnt_q == TimeoutVal) begin
                        sl_d    = 1'b1;
                        cnt_d   = '0;
                        state_d = StArm;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StWaitLow: begin
                    if (fall) begin
                        sh_d    = 1'b0;
                        state_d = StArm;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = valid_q;
    assign stuck_high = sh_q;
    assign stuck_low  = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: clock-aligned PWM stimulus with a scoreboard of expected
// (period, high_time) pairs popped whenever meas_valid fires.
module tb_pwm_capture;

    localparam int W  = 16;
    localparam int TO = 50;
    localparam int SS = 2;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         pwm_in;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         meas_valid;
    logic         stuck_high;
    logic         stuck_low;

    pwm_capture #(
        .CNT_W      (W),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .stuck_high(stuck_high),
        .stuck_low (stuck_low)
    );

    typedef struct packed {
        logic [W-1:0] per;
        logic [W-1:0] hi;
        logic         gap;
    } exp_t;

    exp_t sb[$];

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_mv_cyc  = 0;
    logic mv_prev    = 1'b0;

    // Stimulus model: the last complete high/low pair the DUT has seen.
    bit   have_prev   = 0;
    bit   prev_pushed = 0;
    bit   cur_pushed  = 0;
    int   prev_h      = 0;
    int   prev_l      = 0;
    logic [W-1:0] last_per = '0;
    logic [W-1:0] last_hi  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (meas_valid) begin
            exp_t e;
            tests_run++;
            if (mv_prev !== 1'b0) begin
                tests_failed++;
                $display("FAIL mv_width: meas_valid high %0d cycles running, required 1", 2);
            end
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_meas: period=%0d high_time=%0d, required no meas_valid",
                         period, high_time);
            end else begin
                e = sb.pop_front();
                tests_run++;
                if (period !== e.per) begin
                    tests_failed++;
                    $display("FAIL meas_period: got %0d, required %0d", period, e.per);
                end
                tests_run++;
                if (high_time !== e.hi) begin
                    tests_failed++;
                    $display("FAIL meas_high: got %0d, required %0d", high_time, e.hi);
                end
                if (e.gap) begin
                    tests_run++;
                    if ((cyc - last_mv_cyc) !== int'(e.per)) begin
                        tests_failed++;
                        $display("FAIL meas_spacing: got %0d cycles, required %0d",
                                 cyc - last_mv_cyc, e.per);
                    end
                end
            end
            last_mv_cyc = cyc;
        end
        mv_prev = meas_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_rise();
        exp_t e;
        cur_pushed = have_prev;
        if (have_prev) begin
            e.per    = W'(prev_h + prev_l);
            e.hi     = W'(prev_h);
            e.gap    = prev_pushed;
            last_per = e.per;
            last_hi  = e.hi;
            sb.push_back(e);
        end
        pwm_in = 1'b1;
    endtask

    task automatic end_pulse(input int h, input int l);
        have_prev   = 1;
        prev_h      = h;
        prev_l      = l;
        prev_pushed = cur_pushed;
    endtask

    task automatic break_stream();
        have_prev   = 0;
        prev_pushed = 0;
    endtask

    task automatic pulse(input int h, input int l);
        start_rise();
        repeat (h) step();
        pwm_in = 1'b0;
        repeat (l) step();
        end_pulse(h, l);
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (2) step();
        @(negedge clk);
        tests_run++;
        if (period !== '0) begin tests_failed++; $display("FAIL reset_period: got %0d, required 0", period); end
        tests_run++;
        if (high_time !== '0) begin tests_failed++; $display("FAIL reset_high: got %0d, required 0", high_time); end
        tests_run++;
        if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b, required 0", meas_valid); end
        tests_run++;
        if (stuck_high !== 1'b0) begin tests_failed++; $display("FAIL reset_sh: got %b, required 0", stuck_high); end
        tests_run++;
        if (stuck_low !== 1'b0) begin tests_failed++; $display("FAIL reset_sl: got %b, required 0", stuck_low); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        enable = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 5; i++) pulse(3, 7);
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL basic_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_switch();
        pulse(8, 2);
        pulse(3, 5);
        pulse(8, 2);
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL switch_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_stuck_low();
        pulse(8, 2);
        repeat (TO + SS - 10) step();
        @(negedge clk);
        tests_run++;
        if (stuck_low !== 1'b0) begin tests_failed++; $display("FAIL sl_early: got %b, required 0", stuck_low); end
        step();
        @(negedge clk);
        tests_run++;
        if (stuck_low !== 1'b1) begin tests_failed++; $display("FAIL sl_set: got %b, required 1", stuck_low); end
        tests_run++;
        if (stuck_high !== 1'b0) begin tests_failed++; $display("FAIL sl_sh: got %b, required 0", stuck_high); end
        break_stream();
        repeat (5) step();
        start_rise();
        step();
        step();
        @(negedge clk);
        tests_run++;
        if (stuck_low !== 1'b1) begin tests_failed++; $display("FAIL sl_hold: got %b, required 1", stuck_low); end
        step();
        @(negedge clk);
        tests_run++;
        if (stuck_low !== 1'b0) begin tests_failed++; $display("FAIL sl_clear: got %b, required 0", stuck_low); end
        pwm_in = 1'b0;
        repeat (7) step();
        end_pulse(3, 7);
        pulse(3, 7);
    endtask

    task automatic test_stuck_high();
        start_rise();
        repeat (TO + SS) step();
        @(negedge clk);
        tests_run++;
        if (stuck_high !== 1'b0) begin tests_failed++; $display("FAIL sh_early: got %b, required 0", stuck_high); end
        step();
        @(negedge clk);
        tests_run++;
        if (stuck_high !== 1'b1) begin tests_failed++; $display("FAIL sh_set: got %b, required 1", stuck_high); end
        break_stream();
        repeat (10) step();
        pwm_in = 1'b0;
        step();
        step();
        @(negedge clk);
        tests_run++;
        if (stuck_high !== 1'b1) begin tests_failed++; $display("FAIL sh_hold: got %b, required 1", stuck_high); end
        step();
        @(negedge clk);
        tests_run++;
        if (stuck_high !== 1'b0) begin tests_failed++; $display("FAIL sh_clear: got %b, required 0", stuck_high); end
        repeat (5) step();
        pulse(4, 6);
        pulse(4, 6);
        pulse(2, 3);
    endtask

    task automatic test_enable_drop();
        pulse(5, 5);
        pulse(5, 5);
        start_rise();
        repeat (4) step();
        enable = 1'b0;
        break_stream();
        repeat (2) step();
        pwm_in = 1'b0;
        repeat (3) step();
        @(negedge clk);
        tests_run++;
        if (period !== last_per) begin tests_failed++; $display("FAIL en_period: got %0d, required %0d", period, last_per); end
        tests_run++;
        if (high_time !== last_hi) begin tests_failed++; $display("FAIL en_high: got %0d, required %0d", high_time, last_hi); end
        enable = 1'b1;
        repeat (4) step();
        pulse(3, 4);
        pulse(2, 5);
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL en_drain: %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        tests_run++;
        if (period !== last_per) begin tests_failed++; $display("FAIL pre_rst_period: got %0d, required %0d", period, last_per); end
        rst = 1'b1;
        step();
        @(negedge clk);
        tests_run++;
        if (period !== '0) begin tests_failed++; $display("FAIL rst2_period: got %0d, required 0", period); end
        tests_run++;
        if (high_time !== '0) begin tests_failed++; $display("FAIL rst2_high: got %0d, required 0", high_time); end
        tests_run++;
        if (meas_valid !== 1'b0) begin tests_failed++; $display("FAIL rst2_valid: got %b, required 0", meas_valid); end
        rst = 1'b0;
        break_stream();
        repeat (3) step();
        for (int i = 0; i < 6; i++) pulse(1, 1);
        repeat (6) step();
        tests_run++;
        if (sb.size() !== 0) begin
            tests_failed++;
            $display("FAIL fast_drain: %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_switch();
        test_stuck_low();
        test_stuck_high();
        test_enable_drop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
